// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU package for the hazard unit.
// Holds the syscall FSM state encoding, the E-stage forward-select codes,
// and a helper that resolves one E-stage operand's forward select.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    WAIT_ACK = 2'd2,
    RESUME   = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwd_sel_e(input logic [4:0] rs,
                                           input logic       rwm,
                                           input logic [4:0] wm,
                                           input logic       rww,
                                           input logic [4:0] ww);
    if (rwm && (wm != 5'd0) && (wm == rs))      return FWD_M;
    else if (rww && (ww != 5'd0) && (ww == rs)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones.
// Ports: clk, rst_n (async low), inc (count this cycle), count (value).
// INIT is the value loaded by reset; it stays zero in normal use.
module sat_counter32 #(
  parameter logic [31:0] INIT = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               count_q <= INIT;
    else if (inc && (count_q != 32'hFFFF_FFFF)) count_q <= count_q + 32'd1;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage CPU.
//   Inputs : D/E/M/W register specifiers and control bits, branch/jump
//            info, syscall in E and the external handler's ack.
//   Outputs: stallf/stalld/flushd/flushe, D-stage and E-stage forward
//            selects, registered syscall_req, stall/flush perf counters.
// A syscall in E drains the pipe for two cycles, raises syscall_req until
// the handler acks, then spends one RESUME cycle before running again;
// the front end is held stalled for the whole sequence.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter logic [31:0] CNT_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rsd,
  input  logic [4:0]  rtd,
  input  logic [4:0]  rse,
  input  logic [4:0]  rte,
  input  logic [4:0]  writerege,
  input  logic [4:0]  writeregm,
  input  logic [4:0]  writeregw,
  input  logic        regwritee,
  input  logic        regwritem,
  input  logic        regwritew,
  input  logic        memtorege,
  input  logic        memtoregm,
  input  logic        branchd,
  input  logic        pcsrcd,
  input  logic        jumpd,
  input  logic        syscalle,
  input  logic        syscall_ack,
  output logic        stallf,
  output logic        stalld,
  output logic        flushd,
  output logic        flushe,
  output logic        forwardad,
  output logic        forwardbd,
  output logic [1:0]  forwardae,
  output logic [1:0]  forwardbe,
  output logic        syscall_req,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  hz_state_e  state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       syscall_req_q, syscall_req_d;
  logic       lwstall, brstall, stall;

  // Load in E feeding an operand of the instruction in D.
  assign lwstall = memtorege && (rte != 5'd0) && ((rte == rsd) || (rte == rtd));

  // Branch compares in D need results not yet forwardable from M.
  assign brstall = branchd &&
    ((regwritee && (writerege != 5'd0) && ((writerege == rsd) || (writerege == rtd))) ||
     (memtoregm && (writeregm != 5'd0) && ((writeregm == rsd) || (writeregm == rtd))));

  assign stall  = lwstall || brstall || (state_q != RUN);
  assign stallf = stall;
  assign stalld = stall;
  assign flushe = stall;
  assign flushd = (pcsrcd || jumpd) && !stall;

  assign forwardad = regwritem && (rsd != 5'd0) && (writeregm == rsd);
  assign forwardbd = regwritem && (rtd != 5'd0) && (writeregm == rtd);
  assign forwardae = fwd_sel_e(rse, regwritem, writeregm, regwritew, writeregw);
  assign forwardbe = fwd_sel_e(rte, regwritem, writeregm, regwritew, writeregw);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: if (syscalle) begin
        state_d = DRAIN;
        drain_d = 2'd2;
      end
      DRAIN: begin
        drain_d = (drain_q != 2'd0) ? drain_q - 2'd1 : 2'd0;
        if (drain_q <= 2'd1) state_d = WAIT_ACK;
      end
      WAIT_ACK: if (syscall_ack) state_d = RESUME;
      RESUME:   state_d = RUN;
      default:  state_d = RUN;
    endcase
    // Registered so the request is high exactly during WAIT_ACK.
    syscall_req_d = (state_d == WAIT_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      drain_q       <= 2'd0;
      syscall_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      syscall_req_q <= syscall_req_d;
    end
  end

  assign syscall_req = syscall_req_q;

  sat_counter32 #(.INIT(CNT_INIT)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter32 #(.INIT(CNT_INIT)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall || flushd),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Stimulus pushes hand-computed expected
// values into a queue; the monitor pops and compares them on the falling
// edge. A second instance with counters preloaded to 0xFFFFFFFE covers
// saturation without billions of cycles.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk, rst_n;
  logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
  logic regwritee, regwritem, regwritew, memtorege, memtoregm;
  logic branchd, pcsrcd, jumpd, syscalle, syscall_ack;
  logic stallf, stalld, flushd, flushe, forwardad, forwardbd, syscall_req;
  logic [1:0] forwardae, forwardbe;
  logic [31:0] stall_cnt, flush_cnt;
  logic stallf2, stalld2, flushd2, flushe2, fad2, fbd2, sreq2;
  logic [1:0] fae2, fbe2;
  logic [31:0] stall_cnt2, flush_cnt2;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
    .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
    .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
    .memtorege(memtorege), .memtoregm(memtoregm), .branchd(branchd),
    .pcsrcd(pcsrcd), .jumpd(jumpd), .syscalle(syscalle), .syscall_ack(syscall_ack),
    .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe),
    .forwardad(forwardad), .forwardbd(forwardbd), .forwardae(forwardae),
    .forwardbe(forwardbe), .syscall_req(syscall_req),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_INIT(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
    .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
    .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
    .memtorege(memtorege), .memtoregm(memtoregm), .branchd(branchd),
    .pcsrcd(pcsrcd), .jumpd(jumpd), .syscalle(syscalle), .syscall_ack(syscall_ack),
    .stallf(stallf2), .stalld(stalld2), .flushd(flushd2), .flushe(flushe2),
    .forwardad(fad2), .forwardbd(fbd2), .forwardae(fae2),
    .forwardbe(fbe2), .syscall_req(sreq2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {
    S_STALLF, S_STALLD, S_FLUSHE, S_FLUSHD, S_FAE, S_FBE, S_FAD, S_FBD,
    S_REQ, S_SCNT, S_FCNT, S_SCNT2, S_FCNT2
  } sig_e;

  typedef struct {
    string       nm;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input string nm, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.nm = nm; e.sig = sig; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_stall(input string nm, input logic v);
    expect_v({nm, "_stallf"}, S_STALLF, {31'd0, v});
    expect_v({nm, "_stalld"}, S_STALLD, {31'd0, v});
    expect_v({nm, "_flushe"}, S_FLUSHE, {31'd0, v});
  endtask

  // Monitor: compares everything queued for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = exp_q.pop_front();
        case (e.sig)
          S_STALLF: act = {31'd0, stallf};
          S_STALLD: act = {31'd0, stalld};
          S_FLUSHE: act = {31'd0, flushe};
          S_FLUSHD: act = {31'd0, flushd};
          S_FAE:    act = {30'd0, forwardae};
          S_FBE:    act = {30'd0, forwardbe};
          S_FAD:    act = {31'd0, forwardad};
          S_FBD:    act = {31'd0, forwardbd};
          S_REQ:    act = {31'd0, syscall_req};
          S_SCNT:   act = stall_cnt;
          S_FCNT:   act = flush_cnt;
          S_SCNT2:  act = stall_cnt2;
          default:  act = flush_cnt2;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", e.nm, act, e.val, $time);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rsd = 0; rtd = 0; rse = 0; rte = 0;
    writerege = 0; writeregm = 0; writeregw = 0;
    regwritee = 0; regwritem = 0; regwritew = 0;
    memtorege = 0; memtoregm = 0;
    branchd = 0; pcsrcd = 0; jumpd = 0; syscalle = 0; syscall_ack = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    cyc();
    // Reset state
    expect_stall("rst", 1'b0);
    expect_v("rst_flushd", S_FLUSHD, 0);
    expect_v("rst_req", S_REQ, 0);
    expect_v("rst_scnt", S_SCNT, 0);
    expect_v("rst_fcnt", S_FCNT, 0);
    expect_v("rst_fae", S_FAE, {30'd0, FWD_RF});
    expect_v("rst_scnt_pre", S_SCNT2, 32'hFFFF_FFFE);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Load-use on rsd
    memtorege = 1; rte = 5; rsd = 5;
    expect_stall("lu", 1'b1);
    expect_v("lu_flushd", S_FLUSHD, 0);
    expect_v("lu_scnt0", S_SCNT, 0);
    cyc();
    clr();
    expect_stall("lu_clr", 1'b0);
    expect_v("lu_scnt1", S_SCNT, 1);
    expect_v("lu_fcnt1", S_FCNT, 1);
    cyc();
    // r0 never creates a hazard
    memtorege = 1; rte = 0; rsd = 0;
    expect_stall("lu_r0", 1'b0);
    cyc();
    // Load-use on rtd
    memtorege = 1; rte = 5; rsd = 1; rtd = 5;
    expect_stall("lu_rt", 1'b1);
    cyc();
    clr();
    expect_v("lu_scnt2", S_SCNT, 2);
    expect_v("lu_fcnt2", S_FCNT, 2);
    cyc();

    // Forwarding priority
    rse = 3; rte = 3; rsd = 3; writeregm = 3; regwritem = 1; writeregw = 3; regwritew = 1;
    expect_v("fwd_ae_m", S_FAE, {30'd0, FWD_M});
    expect_v("fwd_be_m", S_FBE, {30'd0, FWD_M});
    expect_v("fwd_ad", S_FAD, 1);
    expect_v("fwd_bd", S_FBD, 0);
    expect_stall("fwd", 1'b0);
    cyc();
    regwritem = 0;
    expect_v("fwd_ae_w", S_FAE, {30'd0, FWD_W});
    expect_v("fwd_ad_off", S_FAD, 0);
    cyc();
    rse = 0;
    expect_v("fwd_ae_rf", S_FAE, {30'd0, FWD_RF});
    expect_v("fwd_be_w", S_FBE, {30'd0, FWD_W});
    cyc();
    clr();

    // Taken branch / jump
    pcsrcd = 1;
    expect_v("br_flushd", S_FLUSHD, 1);
    expect_v("br_stalld", S_STALLD, 0);
    cyc();
    branchd = 1; regwritee = 1; writerege = 7; rsd = 7;
    expect_v("brst_flushd", S_FLUSHD, 0);
    expect_v("brst_stalld", S_STALLD, 1);
    cyc();
    clr();
    branchd = 1; memtoregm = 1; writeregm = 4; rtd = 4; jumpd = 1;
    expect_v("brm_flushd", S_FLUSHD, 0);
    expect_v("brm_stalld", S_STALLD, 1);
    cyc();
    clr();
    branchd = 1; regwritee = 1; writerege = 0; rsd = 0; jumpd = 1;
    expect_v("br_r0_flushd", S_FLUSHD, 1);
    expect_v("br_r0_stalld", S_STALLD, 0);
    cyc();
    clr();
    expect_v("br_scnt", S_SCNT, 4);
    expect_v("br_fcnt", S_FCNT, 6);
    cyc();

    // Syscall sequence
    do_reset();
    syscalle = 1;
    expect_stall("sc_t0", 1'b0);
    expect_v("sc_t0_req", S_REQ, 0);
    cyc();
    syscalle = 0; syscall_ack = 1;  // ack outside WAIT_ACK is ignored
    expect_stall("sc_drain1", 1'b1);
    expect_v("sc_drain1_req", S_REQ, 0);
    cyc();
    syscall_ack = 0; syscalle = 1;  // syscall outside RUN is ignored
    expect_stall("sc_drain2", 1'b1);
    expect_v("sc_drain2_req", S_REQ, 0);
    cyc();
    syscalle = 0;
    for (int i = 0; i < 5; i++) begin
      expect_v("sc_wait_req", S_REQ, 1);
      expect_v("sc_wait_stalld", S_STALLD, 1);
      cyc();
    end
    syscall_ack = 1;
    expect_v("sc_ack_req", S_REQ, 1);
    cyc();
    syscall_ack = 0;
    expect_stall("sc_resume", 1'b1);
    expect_v("sc_resume_req", S_REQ, 0);
    cyc();
    expect_stall("sc_run", 1'b0);
    expect_v("sc_run_req", S_REQ, 0);
    expect_v("sc_scnt", S_SCNT, 9);
    expect_v("sc_fcnt", S_FCNT, 9);
    cyc();
    expect_v("sc_run2_stalld", S_STALLD, 0);
    cyc();

    // Reset in the middle of WAIT_ACK
    syscalle = 1;
    cyc();
    syscalle = 0;
    cyc();
    cyc();
    expect_v("rw_req", S_REQ, 1);
    expect_v("rw_scnt", S_SCNT, 11);
    cyc();
    rst_n = 1'b0;  // checked before the next rising edge
    expect_v("rw_req0", S_REQ, 0);
    expect_stall("rw", 1'b0);
    expect_v("rw_scnt0", S_SCNT, 0);
    expect_v("rw_fcnt0", S_FCNT, 0);
    cyc();
    rst_n = 1'b1;
    expect_v("rw_after_req", S_REQ, 0);
    expect_v("rw_after_stalld", S_STALLD, 0);
    cyc();

    // Saturation on the preloaded instance
    do_reset();
    memtorege = 1; rte = 5; rsd = 5;
    expect_v("sat_c1", S_SCNT2, 32'hFFFF_FFFE);
    cyc();
    expect_v("sat_c2", S_SCNT2, 32'hFFFF_FFFF);
    cyc();
    expect_v("sat_c3", S_SCNT2, 32'hFFFF_FFFF);
    cyc();
    clr();
    expect_v("sat_hold", S_SCNT2, 32'hFFFF_FFFF);
    expect_v("sat_fhold", S_FCNT2, 32'hFFFF_FFFF);
    expect_v("sat_ref", S_SCNT, 3);
    cyc();
    memtorege = 1; rte = 5; rsd = 5;
    cyc();
    clr();
    expect_v("sat_hold2", S_SCNT2, 32'hFFFF_FFFF);
    expect_v("sat_ref2", S_SCNT, 4);
    cyc();

    begin : drain_wait
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
        cyc();
        n++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
